record_serial_tx: RTL and testbench

- Reader/transmitter side of the 35-bit smart-house record store.
- Accepts one 35-bit record per valid/ready handshake, taken from the memory unit's data output.
- Shifts the record out on a single-wire UART-style line: start bit, 35 data bits LSB first, optional parity, stop bit.
- Feeds the house status link to the display/host side.

---
 rtl/record_pkg.sv | 21 ++
 rtl/record_serial_tx_if.sv | 12 +
 rtl/baud_tick_gen.sv | 32 +++
 rtl/record_serial_tx.sv | 144 ++++++++++++++
 tb/tb_record_serial_tx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/record_pkg.sv
// Shared definitions for the 35-bit smart-house record path (memory unit, transmitter, receiver).
package record_pkg;

   localparam int REC_W            = 35;
   localparam int BIT_CNT_W        = $clog2(REC_W);
   localparam int FRAME_BITS_NOPAR = REC_W + 2;
   localparam int FRAME_BITS_PAR   = REC_W + 3;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   function automatic logic even_parity(input logic [REC_W-1:0] rec);
      return ^rec;
   endfunction

endpackage

// File: rtl/record_serial_tx_if.sv
// Valid/ready record handshake between the memory unit (master) and the serial transmitter (slave).
interface record_serial_tx_if;
   import record_pkg::*;

   logic             rec_valid;
   logic [REC_W-1:0] rec_data;
   logic             rec_ready;

   modport master (output rec_valid, output rec_data, input  rec_ready);
   modport slave  (input  rec_valid, input  rec_data, output rec_ready);

endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last and next-to-last cycle of each bit.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic arst,
   input  logic i_clr,
   output logic o_bit_end,
   output logic o_bit_pre_end
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (arst || i_clr) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_bit_end     = (r_cnt == LAST);
   assign o_bit_pre_end = (r_cnt == PRE);

endmodule

// File: rtl/record_serial_tx.sv
// Serial transmitter for 35-bit records: start, data LSB first, optional even parity, stop.
// Parity bit is enabled by defining RECORD_SERIAL_TX_PARITY_EN.
module record_serial_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int CNT_W        = 8
) (
   input  logic               clk,
   input  logic               arst,
   record_serial_tx_if.slave  rec_if,
   output logic               tx,
   output logic               tx_busy,
   output logic               frame_done,
   output logic [CNT_W-1:0]   frames_sent
);
   import record_pkg::*;

   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(REC_W - 1);

   state_t               r_state;
   logic [REC_W-1:0]     r_shift;
   logic [BIT_CNT_W-1:0] r_bit_cnt;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_ready;
   logic                 r_done;
   logic [CNT_W-1:0]     r_frames;
`ifdef RECORD_SERIAL_TX_PARITY_EN
   logic                 r_par;
`endif

   logic w_bit_end;
   logic w_bit_pre_end;
   logic w_xfer;
   logic w_idle;

   assign w_xfer = rec_if.rec_valid & r_ready;
   assign w_idle = (r_state == IDLE);

   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk           (clk),
      .arst          (arst),
      .i_clr         (w_idle),
      .o_bit_end     (w_bit_end),
      .o_bit_pre_end (w_bit_pre_end)
   );

   always_ff @(posedge clk) begin
      if (arst) begin
         r_state   <= IDLE;
         // NOTE: the shift register is cleared too, so nothing from an aborted frame survives reset.
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_ready   <= 1'b0;
         r_done    <= 1'b0;
         r_frames  <= '0;
`ifdef RECORD_SERIAL_TX_PARITY_EN
         r_par     <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               if (w_xfer) begin
                  r_state   <= START;
                  r_shift   <= rec_if.rec_data;
                  r_bit_cnt <= '0;
                  r_tx      <= 1'b0;
                  r_busy    <= 1'b1;
                  r_ready   <= 1'b0;
`ifdef RECORD_SERIAL_TX_PARITY_EN
                  r_par     <= even_parity(rec_if.rec_data);
`endif
               end
            end

            START: begin
               if (w_bit_end) begin
                  r_state <= DATA;
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
               end
            end

            DATA: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == LAST_BIT) begin
`ifdef RECORD_SERIAL_TX_PARITY_EN
                     r_state <= PAR;
                     r_tx    <= r_par;
`else
                     r_state <= STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                     r_tx      <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                  end
               end
            end

            PAR: begin
               if (w_bit_end) begin
                  r_state <= STOP;
                  r_tx    <= 1'b1;
               end
            end

            STOP: begin
               // frame_done is registered, so it is raised one edge early to land in the last stop cycle.
               if (w_bit_pre_end) begin
                  r_done <= 1'b1;
               end
               if (w_bit_end) begin
                  r_state  <= IDLE;
                  r_busy   <= 1'b0;
                  r_ready  <= 1'b1;
                  r_frames <= r_frames + CNT_W'(1);
               end
            end

            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx               = r_tx;
   assign tx_busy          = r_busy;
   assign frame_done       = r_done;
   assign frames_sent      = r_frames;
   assign rec_if.rec_ready = r_ready;

endmodule

// File: tb/tb_record_serial_tx.sv
// Self-checking bench for record_serial_tx (CLKS_PER_BIT=4); honours RECORD_SERIAL_TX_PARITY_EN.
module tb_record_serial_tx;
   import record_pkg::*;

   localparam int CPB   = 4;
   localparam int CNT_W = 8;
`ifdef RECORD_SERIAL_TX_PARITY_EN
   localparam int NBITS = REC_W + 3;
`else
   localparam int NBITS = REC_W + 2;
`endif
   localparam int FLEN = NBITS * CPB;

   logic             clk = 1'b0;
   logic             arst;
   logic             tx;
   logic             tx_busy;
   logic             frame_done;
   logic [CNT_W-1:0] frames_sent;

   int n_checks   = 0;
   int n_fail     = 0;
   int exp_frames = 0;

   record_serial_tx_if rec_if ();

   record_serial_tx #(
      .CLKS_PER_BIT (CPB),
      .CNT_W        (CNT_W)
   ) dut (
      .clk         (clk),
      .arst        (arst),
      .rec_if      (rec_if),
      .tx          (tx),
      .tx_busy     (tx_busy),
      .frame_done  (frame_done),
      .frames_sent (frames_sent)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: line level of frame bit slot idx (0 = start, 1..REC_W = data LSB first, then parity, then stop).
   function automatic logic exp_bit(input logic [REC_W-1:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= REC_W) return d[idx-1];
      if (NBITS == REC_W + 3 && idx == REC_W + 1) return ^d;
      return 1'b1;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_tx"}, 64'(tx), 64'd1);
      check({tag, "_busy"}, 64'(tx_busy), 64'd0);
      check({tag, "_done"}, 64'(frame_done), 64'd0);
      check({tag, "_frames"}, 64'(frames_sent), 64'(exp_frames));
   endtask

   task automatic do_reset();
      arst = 1'b1;
      rec_if.rec_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         exp_frames = 0;
         check_idle("rst");
         check("rst_ready", 64'(rec_if.rec_ready), 64'd0);
      end
      arst = 1'b0;
      @(negedge clk);
      check_idle("post_rst");
      check("post_rst_ready", 64'(rec_if.rec_ready), 64'd1);
   endtask

   // Called at a negedge; returns at the negedge of the first cycle after the handshake edge.
   task automatic start_xfer(input logic [REC_W-1:0] d);
      int waited = 0;
      while (rec_if.rec_ready !== 1'b1 && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      check("xfer_ready_wait", 64'(rec_if.rec_ready), 64'd1);
      rec_if.rec_valid = 1'b1;
      rec_if.rec_data  = d;
      @(negedge clk);
   endtask

   // Checks every cycle of the frame, then the IDLE cycle that follows it.
   task automatic check_frame(input logic [REC_W-1:0] d);
      for (int k = 1; k <= FLEN; k++) begin
         check($sformatf("tx_c%0d", k), 64'(tx), 64'(exp_bit(d, (k - 1) / CPB)));
         check($sformatf("done_c%0d", k), 64'(frame_done), 64'(k == FLEN));
         check($sformatf("busy_c%0d", k), 64'(tx_busy), 64'd1);
         check($sformatf("ready_c%0d", k), 64'(rec_if.rec_ready), 64'd0);
         check($sformatf("frames_c%0d", k), 64'(frames_sent), 64'(exp_frames));
         if (k < FLEN) @(negedge clk);
      end
      @(negedge clk);
      exp_frames = (exp_frames + 1) % (1 << CNT_W);
      check_idle("end");
      check("end_ready", 64'(rec_if.rec_ready), 64'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [REC_W-1:0] d;
      arst = 1'b1;
      rec_if.rec_valid = 1'b0;
      rec_if.rec_data  = '0;
      @(negedge clk);
      do_reset();

      // Single frame.
      start_xfer(35'h2_8900_1125);
      rec_if.rec_valid = 1'b0;
      check_frame(35'h2_8900_1125);

      // Back-to-back with rec_valid held high.
      start_xfer(35'h0_7000_0055);
      rec_if.rec_data = 35'h7_FFFF_FFFF;
      check_frame(35'h0_7000_0055);
      check("b2b_valid_held", 64'(rec_if.rec_valid), 64'd1);
      @(negedge clk);
      rec_if.rec_valid = 1'b0;
      check_frame(35'h7_FFFF_FFFF);

      // rec_data changes after the handshake must not leak into the frame.
      start_xfer(35'h5_27F0_000F);
      rec_if.rec_data  = '0;
      rec_if.rec_valid = 1'b0;
      check_frame(35'h5_27F0_000F);

`ifdef RECORD_SERIAL_TX_PARITY_EN
      start_xfer(35'h0_0000_0007);
      rec_if.rec_valid = 1'b0;
      check_frame(35'h0_0000_0007);
      start_xfer(35'h0_0000_0003);
      rec_if.rec_valid = 1'b0;
      check_frame(35'h0_0000_0003);
`endif

      // Random records with random idle gaps; enough frames to wrap frames_sent.
      for (int n = 0; n < 260; n++) begin
         d = 35'({$urandom, $urandom});
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            check_idle("gap");
            check("gap_ready", 64'(rec_if.rec_ready), 64'd1);
            @(negedge clk);
         end
         start_xfer(d);
         rec_if.rec_valid = 1'b0;
         rec_if.rec_data  = 35'({$urandom, $urandom});
         check_frame(d);
      end

      // Reset together with rec_valid: reset wins.
      arst = 1'b1;
      rec_if.rec_valid = 1'b1;
      rec_if.rec_data  = 35'h1_2345_6789;
      @(negedge clk);
      exp_frames = 0;
      check_idle("rstv");
      check("rstv_ready", 64'(rec_if.rec_ready), 64'd0);
      rec_if.rec_valid = 1'b0;
      arst = 1'b0;
      @(negedge clk);
      check_idle("rstv_rel");
      check("rstv_rel_ready", 64'(rec_if.rec_ready), 64'd1);

      // Mid-frame reset during data bit 10 (cycles 45..48 after the handshake).
      do_reset();
      d = 35'h7_7777_7007;
      start_xfer(d);
      rec_if.rec_valid = 1'b0;
      for (int k = 1; k <= 46; k++) begin
         check($sformatf("abort_tx_c%0d", k), 64'(tx), 64'(exp_bit(d, (k - 1) / CPB)));
         if (k < 46) @(negedge clk);
      end
      arst = 1'b1;
      @(negedge clk);
      check_idle("abort");
      check("abort_ready", 64'(rec_if.rec_ready), 64'd0);
      arst = 1'b0;
      @(negedge clk);
      check("abort_rel_ready", 64'(rec_if.rec_ready), 64'd1);
      for (int k = 0; k < FLEN; k++) begin
         check_idle("abort_after");
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
